lfo_ctrl_rx: RTL and testbench

LFO_CTRL_RX -- requirements
Module: lfo_ctrl_rx

---
 rtl/lfo_ctrl_pkg.sv | 36 +++
 rtl/lfo_ctrl_sync.sv | 42 ++++
 rtl/lfo_ctrl_rx.sv | 154 +++++++++++++++
 tb/tb_lfo_ctrl_rx.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/lfo_ctrl_pkg.sv
// lfo_ctrl_pkg: shared constants and types for the LFO control-panel SPI receiver.
//   Frame layout (16 bits, MSB first): [15:12] address, [11] reserved,
//   [10] even parity (checked only when LFO_CTRL_PARITY_EN is defined), [9:0] data.
package lfo_ctrl_pkg;

  localparam int unsigned FRAME_BITS = 16;
  localparam int unsigned DATA_W     = 10;
  localparam int unsigned CNT_W      = 5;

  localparam logic [3:0] ADDR_FREQ = 4'h0;
  localparam logic [3:0] ADDR_PW   = 4'h1;
  localparam logic [3:0] ADDR_WAVE = 4'h2;

  typedef enum logic [1:0] {
    WaveSquare   = 2'b00,
    WaveTriangle = 2'b01,
    WaveSaw      = 2'b10,
    WaveSine     = 2'b11
  } wave_e;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StCheck
  } state_e;

  localparam logic [DATA_W-1:0] FREQ_RST = 10'd512;
  localparam logic [DATA_W-1:0] PW_RST   = 10'd512;
  localparam wave_e             WAVE_RST = WaveSquare;

  // Even parity over the whole frame: all 16 bits XOR to zero.
  function automatic logic parity_ok(input logic [FRAME_BITS-1:0] frame);
    return (^frame) == 1'b0;
  endfunction

endpackage

// File: rtl/lfo_ctrl_sync.sv
// lfo_ctrl_sync: multi-flop synchronizer with rising/falling edge detect.
//   i_clk, i_reset : system clock, async active-high reset
//   i_d            : asynchronous input pin
//   o_q            : synchronized level
//   o_rise, o_fall : one-cycle edge strobes on the synchronized level
// Edge strobes are held off until the chain and history flop contain only real
// pin samples, so the reset value never manufactures an edge after release.
module lfo_ctrl_sync #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        RESET_VAL   = 1'b0
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_d,
  output logic o_q,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_chain;
  logic                   r_prev;
  logic [SYNC_STAGES:0]   r_fill;
  logic                   w_valid;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_chain <= {SYNC_STAGES{RESET_VAL}};
      r_prev  <= RESET_VAL;
      r_fill  <= '0;
    end else begin
      r_chain <= {r_chain[SYNC_STAGES-2:0], i_d};
      r_prev  <= r_chain[SYNC_STAGES-1];
      r_fill  <= {r_fill[SYNC_STAGES-1:0], 1'b1};
    end
  end

  assign w_valid = &r_fill;
  assign o_q     = r_chain[SYNC_STAGES-1];
  assign o_rise  = w_valid & r_chain[SYNC_STAGES-1] & ~r_prev;
  assign o_fall  = w_valid & ~r_chain[SYNC_STAGES-1] & r_prev;

endmodule

// File: rtl/lfo_ctrl_rx.sv
// lfo_ctrl_rx: SPI mode-0 receiver turning 16-bit control frames into LFO settings.
//   clk, reset            : system clock, async active-high reset
//   sclk, cs_n, mosi      : raw SPI pins (asynchronous, synchronized internally)
//   wave_type             : waveform select (00 sq, 01 tri, 10 saw, 11 sine)
//   frequency_in          : frequency control word
//   pulse_width           : square duty control word
//   update                : one-clk pulse when a valid frame is applied
//   frame_err             : one-clk pulse when a frame is discarded
// Build option: define LFO_CTRL_PARITY_EN to enforce even parity in bit [10].
module lfo_ctrl_rx
  import lfo_ctrl_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sclk,
  input  logic              cs_n,
  input  logic              mosi,
  output logic [1:0]        wave_type,
  output logic [DATA_W-1:0] frequency_in,
  output logic [DATA_W-1:0] pulse_width,
  output logic              update,
  output logic              frame_err
);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_BITS + 1);

  logic w_sclk_rise, w_cs_rise, w_cs_fall, w_mosi;
  logic w_sclk_q_unused, w_sclk_fall_unused, w_cs_q_unused;
  logic w_mosi_rise_unused, w_mosi_fall_unused;

  lfo_ctrl_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .i_clk   (clk),
    .i_reset (reset),
    .i_d     (sclk),
    .o_q     (w_sclk_q_unused),
    .o_rise  (w_sclk_rise),
    .o_fall  (w_sclk_fall_unused)
  );

  lfo_ctrl_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
    .i_clk   (clk),
    .i_reset (reset),
    .i_d     (cs_n),
    .o_q     (w_cs_q_unused),
    .o_rise  (w_cs_rise),
    .o_fall  (w_cs_fall)
  );

  lfo_ctrl_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .i_clk   (clk),
    .i_reset (reset),
    .i_d     (mosi),
    .o_q     (w_mosi),
    .o_rise  (w_mosi_rise_unused),
    .o_fall  (w_mosi_fall_unused)
  );

  state_e                r_state, w_state_d;
  logic [FRAME_BITS-1:0] r_shift, w_shift_d;
  logic [CNT_W-1:0]      r_cnt, w_cnt_d;
  logic [DATA_W-1:0]     r_freq, w_freq_d;
  logic [DATA_W-1:0]     r_pw, w_pw_d;
  wave_e                 r_wave, w_wave_d;
  logic                  r_update, w_update_d;
  logic                  r_err, w_err_d;

  logic [3:0] w_addr;
  logic       w_addr_ok;
  logic       w_frame_ok;

  assign w_addr    = r_shift[15:12];
  assign w_addr_ok = (w_addr == ADDR_FREQ) || (w_addr == ADDR_PW) || (w_addr == ADDR_WAVE);

`ifdef LFO_CTRL_PARITY_EN
  assign w_frame_ok = (r_cnt == CNT_FULL) && w_addr_ok && parity_ok(r_shift);
`else
  logic w_parity_unused;
  assign w_parity_unused = ^r_shift[11:10];
  assign w_frame_ok      = (r_cnt == CNT_FULL) && w_addr_ok;
`endif

  always_comb begin
    w_state_d  = r_state;
    w_shift_d  = r_shift;
    w_cnt_d    = r_cnt;
    w_freq_d   = r_freq;
    w_pw_d     = r_pw;
    w_wave_d   = r_wave;
    w_update_d = 1'b0;
    w_err_d    = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_cs_fall) begin
          w_shift_d = '0;
          w_cnt_d   = '0;
          w_state_d = StShift;
        end
      end
      StShift: begin
        if (w_cs_rise) begin
          w_state_d = StCheck;
        end else if (w_sclk_rise && (r_cnt != CNT_SAT)) begin
          // Count one past a full frame so over-long frames are rejected.
          w_cnt_d = r_cnt + 1'b1;
          if (r_cnt < CNT_FULL) w_shift_d = {r_shift[FRAME_BITS-2:0], w_mosi};
        end
      end
      StCheck: begin
        w_state_d = StIdle;
        if (w_frame_ok) begin
          w_update_d = 1'b1;
          if (w_addr == ADDR_FREQ)    w_freq_d = r_shift[DATA_W-1:0];
          else if (w_addr == ADDR_PW) w_pw_d   = r_shift[DATA_W-1:0];
          else                        w_wave_d = wave_e'(r_shift[1:0]);
        end else begin
          w_err_d = 1'b1;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= StIdle;
      r_shift  <= '0;
      r_cnt    <= '0;
      r_freq   <= FREQ_RST;
      r_pw     <= PW_RST;
      r_wave   <= WAVE_RST;
      r_update <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_d;
      r_shift  <= w_shift_d;
      r_cnt    <= w_cnt_d;
      r_freq   <= w_freq_d;
      r_pw     <= w_pw_d;
      r_wave   <= w_wave_d;
      r_update <= w_update_d;
      r_err    <= w_err_d;
    end
  end

  assign wave_type    = r_wave;
  assign frequency_in = r_freq;
  assign pulse_width  = r_pw;
  assign update       = r_update;
  assign frame_err    = r_err;

endmodule

// File: tb/tb_lfo_ctrl_rx.sv
// tb_lfo_ctrl_rx: directed bench for lfo_ctrl_rx; every update/frame_err pulse is
// matched against an expected-result queue filled when each frame is sent.
module tb_lfo_ctrl_rx;

  localparam int SYNC = 2;

  logic       clk = 1'b0;
  logic       reset, sclk, cs_n, mosi;
  logic [1:0] wave_type;
  logic [9:0] frequency_in, pulse_width;
  logic       update, frame_err;

  lfo_ctrl_rx #(.SYNC_STAGES(SYNC)) dut (
    .clk          (clk),
    .reset        (reset),
    .sclk         (sclk),
    .cs_n         (cs_n),
    .mosi         (mosi),
    .wave_type    (wave_type),
    .frequency_in (frequency_in),
    .pulse_width  (pulse_width),
    .update       (update),
    .frame_err    (frame_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         is_err;
    logic [9:0] freq;
    logic [9:0] pw;
    logic [1:0] wave;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;

  logic [9:0] m_freq = 10'd512;
  logic [9:0] m_pw   = 10'd512;
  logic [1:0] m_wave = 2'b00;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] make_word(input logic [3:0] addr, input logic [9:0] data,
                                            input bit flip_parity);
    logic [15:0] w;
    w     = {addr, 2'b00, data};
    w[10] = (^w) ^ flip_parity;
    return w;
  endfunction

  task automatic push(input bit is_err);
    exp_t x;
    x.is_err = is_err;
    x.freq   = m_freq;
    x.pw     = m_pw;
    x.wave   = m_wave;
    sb.push_back(x);
  endtask

  task automatic send_bits(input logic [16:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      mosi = bits[i];
      #40 sclk = 1'b1;
      #40 sclk = 1'b0;
    end
  endtask

  // Sends an n-bit frame and returns the clk count from cs_n rise to the first pulse.
  task automatic send_frame(input logic [15:0] w, input int n, output int lat);
    logic [16:0] b;
    if (n == 17)      b = {w, 1'b0};
    else if (n == 15) b = {2'b00, w[15:1]};
    else              b = {1'b0, w};
    @(posedge clk); #1 cs_n = 1'b0;
    #80;
    send_bits(b, n);
    #40;
    @(posedge clk); #1 cs_n = 1'b1;
    lat = -1;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      if (update || frame_err) begin
        lat = k;
        break;
      end
    end
  endtask

  // Scoreboard: every pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!reset && (update || frame_err)) begin
      check("pulse_exclusive", 32'(update & frame_err), 32'd0);
      if (sb.size() == 0) begin
        check("unexpected_pulse", {30'd0, update, frame_err}, 32'd0);
      end else begin
        e = sb.pop_front();
        check("pulse_kind", 32'(frame_err), 32'(e.is_err));
        check("frequency_in", 32'(frequency_in), 32'(e.freq));
        check("pulse_width", 32'(pulse_width), 32'(e.pw));
        check("wave_type", 32'(wave_type), 32'(e.wave));
      end
    end
  end

  initial begin
    int lat;
    reset = 1'b1; cs_n = 1'b1; sclk = 1'b0; mosi = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_wave", 32'(wave_type), 32'd0);
    check("rst_freq", 32'(frequency_in), 32'd512);
    check("rst_pw", 32'(pulse_width), 32'd512);
    check("rst_pulses", {30'd0, update, frame_err}, 32'd0);
    reset = 1'b0;

    // Idle for 1000 clk: no pulses (monitor), defaults held.
    repeat (1000) @(posedge clk);
    #1;
    check("idle_freq", 32'(frequency_in), 32'd512);
    check("idle_pw", 32'(pulse_width), 32'd512);
    check("idle_wave", 32'(wave_type), 32'd0);

    // Frequency write with latency check.
    m_freq = 10'd300; push(1'b0);
    send_frame(make_word(4'h0, 10'd300, 1'b0), 16, lat);
    check("freq_latency", 32'(lat), 32'(SYNC + 2));
    repeat (3) @(posedge clk);

    // Back-to-back pulse width and wave type.
    m_pw = 10'd800; push(1'b0);
    send_frame(make_word(4'h1, 10'd800, 1'b0), 16, lat);
    m_wave = 2'b11; push(1'b0);
    send_frame(make_word(4'h2, 10'd3, 1'b0), 16, lat);
    check("wave_latency", 32'(lat), 32'(SYNC + 2));
    repeat (3) @(posedge clk);

    // Same value again still pulses update.
    push(1'b0);
    send_frame(make_word(4'h1, 10'd800, 1'b0), 16, lat);
    repeat (3) @(posedge clk);

    // Discarded frames: short, long, bad address.
    push(1'b1);
    send_frame(make_word(4'h0, 10'd5, 1'b0), 15, lat);
    push(1'b1);
    send_frame(make_word(4'h0, 10'd6, 1'b0), 17, lat);
    push(1'b1);
    send_frame(make_word(4'h7, 10'd7, 1'b0), 16, lat);
    check("err_latency", 32'(lat), 32'(SYNC + 2));
    repeat (3) @(posedge clk);

    // Reset after 8 bits of a frequency frame, released with cs_n still low.
    begin
      logic [15:0] w;
      w = make_word(4'h0, 10'd77, 1'b0);
      @(posedge clk); #1 cs_n = 1'b0;
      #80;
      send_bits({9'd0, w[15:8]}, 8);
      reset = 1'b1;
      m_freq = 10'd512; m_pw = 10'd512; m_wave = 2'b00;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      send_bits({9'd0, w[7:0]}, 8);
      #40;
      @(posedge clk); #1 cs_n = 1'b1;
      repeat (12) @(posedge clk);
      #1;
      check("abort_freq", 32'(frequency_in), 32'd512);
      check("abort_pw", 32'(pulse_width), 32'd512);
      check("abort_wave", 32'(wave_type), 32'd0);
    end
    m_freq = 10'd1023; push(1'b0);
    send_frame(make_word(4'h0, 10'd1023, 1'b0), 16, lat);
    repeat (3) @(posedge clk);

    // Inverted parity bit.
`ifdef LFO_CTRL_PARITY_EN
    push(1'b1);
`else
    m_pw = 10'd100; push(1'b0);
`endif
    send_frame(make_word(4'h1, 10'd100, 1'b1), 16, lat);
    repeat (4) @(posedge clk);
    #1;
    check("final_pw", 32'(pulse_width), 32'(m_pw));
    check("final_freq", 32'(frequency_in), 32'd1023);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
